// File: rtl/afe_spi_arbiter.sv
// ---------------------------------------------------------------------------
// afe_spi_arbiter
//
// Shares one SPI shift engine between the two AFE attenuator/switch channels.
// Each channel presents a valid/ready write request; a round-robin arbiter
// accepts one word at a time, shifts it MSB-first on the granted channel's
// SCK/SDI and then pulses that channel's latch enable.
//
// Parameters:
//   CLK_RATE      sysClk frequency in Hz
//   SPI_CLK_RATE  target SCK frequency in Hz
//   DATA_WIDTH    bits per SPI word
//
// Ports:
//   sysClk        system clock
//   sysReset      synchronous, active-high reset
//   reqValid[1:0] per-channel write request
//   reqData       channel i word at [i*DATA_WIDTH +: DATA_WIDTH]
//   reqBroadcast  (AFE_SPI_BROADCAST_EN only) drive channel 0 word on both
//   reqReady[1:0] combinational accept qualifier, IDLE only
//   busy          transaction in progress
//   grant         channel currently being served
//   done[1:0]     one-cycle end-of-transaction strobe
//   AFE_SPI_CLK   per-channel SCK (registered)
//   AFE_SPI_SDI   per-channel serial data (registered)
//   AFE_SPI_LE    per-channel latch enable, active-high (registered)
//
// Optional feature macro: AFE_SPI_BROADCAST_EN
// ---------------------------------------------------------------------------
module afe_spi_arbiter #(
   parameter int CLK_RATE     = 99999001,
   parameter int SPI_CLK_RATE = 10000000,
   parameter int DATA_WIDTH   = 24
) (
   input  logic                    sysClk,
   input  logic                    sysReset,
   input  logic [1:0]              reqValid,
   input  logic [2*DATA_WIDTH-1:0] reqData,
`ifdef AFE_SPI_BROADCAST_EN
   input  logic                    reqBroadcast,
`endif
   output logic [1:0]              reqReady,
   output logic                    busy,
   output logic                    grant,
   output logic [1:0]              done,
   output logic [1:0]              AFE_SPI_CLK,
   output logic [1:0]              AFE_SPI_SDI,
   output logic [1:0]              AFE_SPI_LE
);

   // Half SCK period in sysClk cycles, rounded up and never below one.
   localparam longint H_RAW = (longint'(CLK_RATE) + 2 * longint'(SPI_CLK_RATE) - 1)
                              / (2 * longint'(SPI_CLK_RATE));
   localparam int H  = (H_RAW < 1) ? 1 : int'(H_RAW);
   localparam int CW = (H > 1) ? $clog2(H) : 1;
   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] H_LAST   = CW'(H - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {IDLE, SETUP, SCK_HI, SCK_LO, LATCH, GAP} state_t;

   state_t                state, state_n;
   logic [CW-1:0]         hcnt, hcnt_n;
   logic [BW-1:0]         bcnt, bcnt_n;
   logic [DATA_WIDTH-1:0] shreg, shreg_n;
   logic                  grant_n;
   logic                  last, last_n;
   logic                  bcast, bcast_n;
   logic [1:0]            done_n;
   logic                  phase_end;
   logic                  winner;
   logic                  accept;
   logic                  bcast_req;
   logic [1:0]            lane;
   logic [1:0]            sck_n, sdi_n, le_n;

`ifdef AFE_SPI_BROADCAST_EN
   assign bcast_req = reqBroadcast;
`else
   assign bcast_req = 1'b0;
`endif

   // Round-robin: a lone request wins; on a tie the channel not served last wins.
   always_comb begin
      winner = 1'b0;
      if (reqValid == 2'b10)
         winner = 1'b1;
      else if (reqValid == 2'b11)
         winner = ~last;
   end

   assign reqReady  = (state == IDLE && !sysReset)
                      ? ((winner ? 2'b10 : 2'b01) & reqValid) : 2'b00;
   assign accept    = |reqReady;
   assign busy      = (state != IDLE);
   assign phase_end = (hcnt == H_LAST);

   // State register
   always_ff @(posedge sysClk) begin
      if (sysReset) begin
         state <= IDLE;
         hcnt  <= '0;
         bcnt  <= '0;
         grant <= 1'b0;
         last  <= 1'b1;
         bcast <= 1'b0;
         done  <= 2'b00;
      end else begin
         state <= state_n;
         hcnt  <= hcnt_n;
         bcnt  <= bcnt_n;
         grant <= grant_n;
         last  <= last_n;
         bcast <= bcast_n;
         done  <= done_n;
      end
   end

   // Next-state logic
   always_comb begin
      state_n = state;
      hcnt_n  = hcnt;
      bcnt_n  = bcnt;
      shreg_n = shreg;
      grant_n = grant;
      last_n  = last;
      bcast_n = bcast;
      done_n  = 2'b00;
      if (state != IDLE)
         hcnt_n = phase_end ? '0 : hcnt + CW'(1);
      case (state)
         IDLE: begin
            if (accept) begin
               state_n = SETUP;
               hcnt_n  = '0;
               bcnt_n  = '0;
               shreg_n = winner ? reqData[2*DATA_WIDTH-1:DATA_WIDTH]
                                : reqData[DATA_WIDTH-1:0];
               grant_n = winner;
               last_n  = winner;
               bcast_n = ~winner & bcast_req;
            end
         end
         SETUP:  if (phase_end) state_n = SCK_HI;
         SCK_HI: begin
            // Shift while leaving SCK high so the next bit appears on the falling edge.
            if (phase_end) begin
               state_n = SCK_LO;
               shreg_n = {shreg[DATA_WIDTH-2:0], 1'b0};
            end
         end
         SCK_LO: begin
            if (phase_end) begin
               if (bcnt == BIT_LAST) begin
                  state_n = LATCH;
               end else begin
                  bcnt_n  = bcnt + BW'(1);
                  state_n = SCK_HI;
               end
            end
         end
         LATCH:  if (phase_end) state_n = GAP;
         GAP: begin
            if (phase_end) begin
               state_n = IDLE;
               done_n  = bcast ? 2'b11 : (grant ? 2'b10 : 2'b01);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Output logic: pin values are derived from the next state so the
   // registered pins line up with the state register.
   always_comb begin
      lane  = bcast_n ? 2'b11 : (grant_n ? 2'b10 : 2'b01);
      sck_n = 2'b00;
      sdi_n = 2'b00;
      le_n  = 2'b00;
      case (state_n)
         SETUP, SCK_LO: sdi_n = lane & {2{shreg_n[DATA_WIDTH-1]}};
         SCK_HI: begin
            sck_n = lane;
            sdi_n = lane & {2{shreg_n[DATA_WIDTH-1]}};
         end
         LATCH:   le_n = lane;
         default: ;
      endcase
   end

   always_ff @(posedge sysClk) begin
      if (sysReset) begin
         shreg       <= '0;
         AFE_SPI_CLK <= 2'b00;
         AFE_SPI_SDI <= 2'b00;
         AFE_SPI_LE  <= 2'b00;
      end else begin
         shreg       <= shreg_n;
         AFE_SPI_CLK <= sck_n;
         AFE_SPI_SDI <= sdi_n;
         AFE_SPI_LE  <= le_n;
      end
   end

endmodule

// File: tb/tb_afe_spi_arbiter.sv
`timescale 1ns/1ps
module tb_afe_spi_arbiter;

   localparam int DW = 24;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [1:0]    req_valid;
   logic [2*DW-1:0] req_data;
   logic [1:0]    req_ready;
   logic          busy, grant;
   logic [1:0]    done, sck, sdi, le;

   logic [1:0]    f_valid;
   logic [2*DW-1:0] f_data;
   logic [1:0]    f_ready;
   logic          f_busy, f_grant;
   logic [1:0]    f_done, f_sck, f_sdi, f_le;
`ifdef AFE_SPI_BROADCAST_EN
   logic          req_bcast;
   logic          f_bcast;
`endif

   afe_spi_arbiter dut (
      .sysClk(clk), .sysReset(rst), .reqValid(req_valid), .reqData(req_data),
`ifdef AFE_SPI_BROADCAST_EN
      .reqBroadcast(req_bcast),
`endif
      .reqReady(req_ready), .busy(busy), .grant(grant), .done(done),
      .AFE_SPI_CLK(sck), .AFE_SPI_SDI(sdi), .AFE_SPI_LE(le));

   afe_spi_arbiter #(.CLK_RATE(10000000), .SPI_CLK_RATE(20000000), .DATA_WIDTH(DW)) dut_fast (
      .sysClk(clk), .sysReset(rst), .reqValid(f_valid), .reqData(f_data),
`ifdef AFE_SPI_BROADCAST_EN
      .reqBroadcast(f_bcast),
`endif
      .reqReady(f_ready), .busy(f_busy), .grant(f_grant), .done(f_done),
      .AFE_SPI_CLK(f_sck), .AFE_SPI_SDI(f_sdi), .AFE_SPI_LE(f_le));

   int checks = 0;
   int errors = 0;
   int last_m = 1;   // reference arbiter: channel served last
   int rd_idx = 0;

   // Reference arbitration rule.
   function automatic int model_winner(input logic [1:0] v, input int lst);
      if (v == 2'b01) return 0;
      if (v == 2'b10) return 1;
      return (lst == 0) ? 1 : 0;
   endfunction

   // ---------------- pin monitor / transaction recorder ----------------
   typedef struct {
      logic [1:0]    dn;
      logic [DW-1:0] word0, word1;
      int            bits0, bits1, le0, le1, busy_len, pmin, pmax;
      logic [1:0]    act;
   } rec_t;
   rec_t recq[$];
   rec_t mrec;

   logic [DW-1:0] acc0, acc1;
   int nb0, nb1, nle0, nle1, nbusy, pmin, pmax, last_rise, cyc, fall_cyc, gap_max;
   logic [1:0] act, prev_sck, prev_le;
   bit fall_pending;

   initial begin
      acc0 = '0; acc1 = '0; nb0 = 0; nb1 = 0; nle0 = 0; nle1 = 0; nbusy = 0;
      pmin = 1000000; pmax = 0; last_rise = -1; cyc = 0; fall_cyc = 0; gap_max = 0;
      act = 2'b00; prev_sck = 2'b00; prev_le = 2'b00; fall_pending = 0;
   end

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (rst) begin
         acc0 = '0; acc1 = '0; nb0 = 0; nb1 = 0; nle0 = 0; nle1 = 0; nbusy = 0;
         pmin = 1000000; pmax = 0; last_rise = -1; act = 2'b00;
         prev_sck = 2'b00; prev_le = 2'b00; fall_pending = 0; gap_max = 0;
      end else begin
         if (sck[0] && !prev_sck[0]) begin acc0 = {acc0[DW-2:0], sdi[0]}; nb0 = nb0 + 1; end
         if (sck[1] && !prev_sck[1]) begin acc1 = {acc1[DW-2:0], sdi[1]}; nb1 = nb1 + 1; end
         if (|(sck & ~prev_sck)) begin
            if (last_rise >= 0) begin
               if (cyc - last_rise < pmin) pmin = cyc - last_rise;
               if (cyc - last_rise > pmax) pmax = cyc - last_rise;
            end
            last_rise = cyc;
            if (fall_pending) begin
               if (cyc - fall_cyc > gap_max) gap_max = cyc - fall_cyc;
               fall_pending = 0;
            end
         end
         if (|(prev_le & ~le)) begin fall_pending = 1; fall_cyc = cyc; end
         if (le[0]) nle0 = nle0 + 1;
         if (le[1]) nle1 = nle1 + 1;
         if (busy) nbusy = nbusy + 1;
         act = act | sck | sdi | le;
         if (done != 2'b00) begin
            mrec.dn = done; mrec.word0 = acc0; mrec.word1 = acc1;
            mrec.bits0 = nb0; mrec.bits1 = nb1; mrec.le0 = nle0; mrec.le1 = nle1;
            mrec.busy_len = nbusy; mrec.pmin = pmin; mrec.pmax = pmax; mrec.act = act;
            recq.push_back(mrec);
            acc0 = '0; acc1 = '0; nb0 = 0; nb1 = 0; nle0 = 0; nle1 = 0; nbusy = 0;
            pmin = 1000000; pmax = 0; last_rise = -1; act = 2'b00;
         end
         prev_sck = sck;
         prev_le  = le;
      end
   end

   // ---------------- helpers ----------------
   task automatic do_reset();
      rst = 1'b1;
      req_valid = 2'b00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      rd_idx = recq.size();
      last_m = 1;
   endtask

   // Waits until a request handshake completes; returns the accepted channel.
   task automatic wait_accept(output int ch);
      ch = -1;
      #1;
      for (int k = 0; k < 600; k++) begin
         if (|(req_valid & req_ready)) begin
            ch = req_ready[1] ? 1 : 0;
            @(posedge clk);
            #1;
            return;
         end
         @(negedge clk);
         #1;
      end
      checks++; errors++;
      $display("FAIL accept_timeout: no handshake within 600 cycles, required one");
   endtask

   task automatic wait_done(output rec_t r);
      checks++;
      for (int k = 0; k < 700; k++) begin
         if (rd_idx < recq.size()) begin
            r = recq[rd_idx];
            rd_idx++;
            return;
         end
         @(negedge clk);
         #1;
      end
      errors++;
      r = '{default: 0};
      $display("FAIL done_timeout: no done pulse within 700 cycles, required one");
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      req_valid = 2'b11;
      req_data = '0;
      f_valid = 2'b00;
      f_data = '0;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (busy !== 1'b0 || grant !== 1'b0 || done !== 2'b00) begin errors++;
         $display("FAIL reset_ctrl: busy=%b grant=%b done=%b, required 0 0 00", busy, grant, done); end
      checks++; if ({sck, sdi, le} !== 6'b0) begin errors++;
         $display("FAIL reset_pins: sck=%b sdi=%b le=%b, required all 0", sck, sdi, le); end
      checks++; if (req_ready !== 2'b00) begin errors++;
         $display("FAIL reset_ready: got %b, required 00 while reset high", req_ready); end
      checks++; if (f_busy !== 1'b0 || f_sck !== 2'b00) begin errors++;
         $display("FAIL reset_fast: busy=%b sck=%b, required 0 00", f_busy, f_sck); end
      req_valid = 2'b00;
      rst = 1'b0;
      @(negedge clk);
      req_valid = 2'b11;
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++;
         $display("FAIL reset_first_tie: ready=%b, required 01", req_ready); end
      req_valid = 2'b00;   // withdrawn before the edge: nothing captured
      repeat (3) @(negedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++;
         $display("FAIL drop_before_accept: busy=%b, required 0", busy); end
      last_m = 1;
   endtask

   task automatic test_single();
      int ch;
      rec_t r;
      @(negedge clk);
      req_data = {DW'($urandom), 24'hA5C3F0};
      req_valid = 2'b01;
      wait_accept(ch);
      checks++; if (ch !== model_winner(2'b01, last_m) || grant !== 1'b0 || busy !== 1'b1) begin errors++;
         $display("FAIL single_accept: ch=%0d grant=%b busy=%b, required 0 0 1", ch, grant, busy); end
      last_m = 0;
      req_valid = 2'b00;
      wait_done(r);
      checks++; if (r.word0 !== 24'hA5C3F0 || r.bits0 != DW) begin errors++;
         $display("FAIL single_word: got %h (%0d bits), required a5c3f0 (24 bits)", r.word0, r.bits0); end
      checks++; if (r.pmin != 10 || r.pmax != 10) begin errors++;
         $display("FAIL single_sck_period: min %0d max %0d, required 10", r.pmin, r.pmax); end
      checks++; if (r.le0 != 5) begin errors++;
         $display("FAIL single_le_width: got %0d, required 5", r.le0); end
      checks++; if (r.act !== 2'b01) begin errors++;
         $display("FAIL single_ch1_quiet: active mask %b, required 01", r.act); end
      checks++; if (r.busy_len != 255) begin errors++;
         $display("FAIL single_busy_len: got %0d, required 255", r.busy_len); end
      checks++; if (r.dn !== 2'b01) begin errors++;
         $display("FAIL single_done: got %b, required 01", r.dn); end
      @(negedge clk);
      #1;
      checks++; if (done !== 2'b00 || busy !== 1'b0) begin errors++;
         $display("FAIL single_done_width: done=%b busy=%b, required 00 0", done, busy); end
   endtask

   task automatic test_tie();
      int ch, exp_ch[4];
      logic [DW-1:0] exp_w[4];
      rec_t r;
      do_reset();
      @(negedge clk);
      req_data = {DW'($urandom), DW'($urandom)};
      req_valid = 2'b11;
      for (int i = 0; i < 4; i++) begin
         wait_accept(ch);
         exp_ch[i] = model_winner(2'b11, last_m);
         exp_w[i] = exp_ch[i] ? req_data[2*DW-1:DW] : req_data[DW-1:0];
         checks++; if (ch != exp_ch[i] || grant !== exp_ch[i][0]) begin errors++;
            $display("FAIL tie_order[%0d]: ch=%0d grant=%b, required %0d", i, ch, grant, exp_ch[i]); end
         last_m = exp_ch[i];
         if (exp_ch[i] == 1) req_data[2*DW-1:DW] = DW'($urandom);
         else                req_data[DW-1:0]    = DW'($urandom);
      end
      req_valid = 2'b00;
      for (int i = 0; i < 4; i++) begin
         wait_done(r);
         checks++; if (r.dn !== (exp_ch[i] ? 2'b10 : 2'b01) ||
                       (exp_ch[i] ? r.word1 : r.word0) !== exp_w[i]) begin errors++;
            $display("FAIL tie_txn[%0d]: done=%b w0=%h w1=%h, required ch%0d word %h",
                     i, r.dn, r.word0, r.word1, exp_ch[i], exp_w[i]); end
      end
      checks++; if (gap_max != 11) begin errors++;
         $display("FAIL tie_gap: LE-fall to SCK-rise max %0d, required 11", gap_max); end
   endtask

   task automatic test_held();
      int ch, viol, k;
      logic [DW-1:0] w1;
      rec_t r;
      @(negedge clk);
      req_data = {DW'($urandom), DW'($urandom)};
      w1 = req_data[2*DW-1:DW];
      req_valid = 2'b01;
      wait_accept(ch);
      checks++; if (ch != 0) begin errors++;
         $display("FAIL held_first: ch=%0d, required 0", ch); end
      last_m = 0;
      req_valid = 2'b10;
      viol = 0;
      for (k = 0; k < 400; k++) begin
         @(negedge clk);
         #1;
         if (done !== 2'b00) break;
         if (req_ready[1]) viol++;
      end
      checks++; if (viol != 0) begin errors++;
         $display("FAIL held_ready_busy: ready[1] high %0d cycles, required 0", viol); end
      checks++; if (done !== 2'b01 || req_ready !== 2'b10) begin errors++;
         $display("FAIL held_first_idle: done=%b ready=%b, required 01 10", done, req_ready); end
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      checks++; if (busy !== 1'b1 || grant !== 1'b1) begin errors++;
         $display("FAIL held_accept: busy=%b grant=%b, required 1 1", busy, grant); end
      last_m = 1;
      wait_done(r);
      wait_done(r);
      checks++; if (r.dn !== 2'b10 || r.word1 !== w1 || r.act !== 2'b10) begin errors++;
         $display("FAIL held_txn: done=%b word=%h act=%b, required 10 %h 10", r.dn, r.word1, r.act, w1); end
   endtask

   task automatic test_random();
      int ch, ec;
      logic [1:0] pat;
      logic [DW-1:0] ew;
      rec_t r;
      for (int it = 0; it < 8; it++) begin
         @(negedge clk);
         pat = 2'($urandom_range(1, 3));
         req_data = {DW'($urandom), DW'($urandom)};
         req_valid = pat;
         ec = model_winner(pat, last_m);
         ew = ec ? req_data[2*DW-1:DW] : req_data[DW-1:0];
         wait_accept(ch);
         checks++; if (ch != ec) begin errors++;
            $display("FAIL rand_grant[%0d]: valid=%b ch=%0d, required %0d", it, pat, ch, ec); end
         last_m = ec;
         req_valid = 2'b00;
         repeat ($urandom_range(5, 200)) @(negedge clk);
         req_data = {DW'($urandom), DW'($urandom)};   // ignored while busy
         req_valid = 2'($urandom_range(1, 3));
         @(negedge clk);
         req_valid = 2'b00;
         wait_done(r);
         checks++; if (r.dn !== (ec ? 2'b10 : 2'b01) || (ec ? r.word1 : r.word0) !== ew ||
                       r.busy_len != 255 || r.act !== (ec ? 2'b10 : 2'b01)) begin errors++;
            $display("FAIL rand_txn[%0d]: done=%b w0=%h w1=%h busy=%0d act=%b, required ch%0d word %h busy 255",
                     it, r.dn, r.word0, r.word1, r.busy_len, r.act, ec, ew); end
         repeat (3) @(negedge clk);
         #1;
         checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL rand_idle[%0d]: busy=%b, required 0", it, busy); end
      end
   endtask

   task automatic test_reset_mid();
      int ch, k, npulse;
      logic [DW-1:0] w0;
      rec_t r;
      do_reset();
      @(negedge clk);
      req_data = {DW'($urandom), DW'($urandom)};
      req_valid = 2'b10;
      wait_accept(ch);
      req_valid = 2'b00;
      checks++; if (ch != 1) begin errors++;
         $display("FAIL mid_accept: ch=%0d, required 1", ch); end
      for (k = 0; k < 400; k++) begin
         @(negedge clk);
         #1;
         if (nb1 >= 10) break;
      end
      checks++; if (nb1 != 10) begin errors++;
         $display("FAIL mid_bit10: reached %0d bits, required 10", nb1); end
      rst = 1'b1;
      @(negedge clk);
      #1;
      checks++; if ({sck, sdi, le} !== 6'b0 || busy !== 1'b0 || done !== 2'b00 || grant !== 1'b0) begin errors++;
         $display("FAIL mid_reset_out: sck=%b sdi=%b le=%b busy=%b done=%b grant=%b, required all 0",
                  sck, sdi, le, busy, done, grant); end
      @(negedge clk);
      rst = 1'b0;
      last_m = 1;
      npulse = 0;
      for (k = 0; k < 300; k++) begin
         @(negedge clk);
         #1;
         if (done !== 2'b00 || busy !== 1'b0) npulse++;
      end
      checks++; if (npulse != 0 || recq.size() != rd_idx) begin errors++;
         $display("FAIL mid_no_done: %0d active cycles, %0d records, required 0", npulse, recq.size() - rd_idx); end
      req_data = {DW'($urandom), DW'($urandom)};
      w0 = req_data[DW-1:0];
      req_valid = 2'b11;
      wait_accept(ch);
      req_valid = 2'b00;
      checks++; if (ch != model_winner(2'b11, last_m)) begin errors++;
         $display("FAIL mid_tie: ch=%0d, required %0d", ch, model_winner(2'b11, last_m)); end
      last_m = 0;
      wait_done(r);
      checks++; if (r.word0 !== w0 || r.dn !== 2'b01) begin errors++;
         $display("FAIL mid_tie_txn: word=%h done=%b, required %h 01", r.word0, r.dn, w0); end
   endtask

   task automatic test_param_corner();
      int k, nbusy_f, nrise, lrise, fpmin, fpmax, nle;
      logic [DW-1:0] w, acc;
      logic [1:0] fdone;
      logic psck;
      @(negedge clk);
      w = DW'($urandom);
      f_data = {DW'($urandom), w};
      f_valid = 2'b01;
      #1;
      checks++; if (f_ready !== 2'b01) begin errors++;
         $display("FAIL fast_ready: got %b, required 01", f_ready); end
      @(posedge clk);
      #1;
      f_valid = 2'b00;
      nbusy_f = 0; nrise = 0; lrise = -1; fpmin = 1000; fpmax = 0; nle = 0;
      acc = '0; fdone = 2'b00; psck = 1'b0;
      for (k = 0; k < 200; k++) begin
         @(negedge clk);
         if (f_busy) nbusy_f++;
         if (f_le[0]) nle++;
         if (f_sck[0] && !psck) begin
            acc = {acc[DW-2:0], f_sdi[0]};
            nrise++;
            if (lrise >= 0) begin
               if (k - lrise < fpmin) fpmin = k - lrise;
               if (k - lrise > fpmax) fpmax = k - lrise;
            end
            lrise = k;
         end
         psck = f_sck[0];
         if (f_done !== 2'b00) begin fdone = f_done; break; end
      end
      checks++; if (nbusy_f != 51) begin errors++;
         $display("FAIL fast_busy_len: got %0d, required 51", nbusy_f); end
      checks++; if (acc !== w || nrise != DW) begin errors++;
         $display("FAIL fast_word: got %h (%0d bits), required %h (24 bits)", acc, nrise, w); end
      checks++; if (fpmin != 2 || fpmax != 2 || nle != 1) begin errors++;
         $display("FAIL fast_timing: period %0d..%0d le %0d, required 2..2 le 1", fpmin, fpmax, nle); end
      checks++; if (fdone !== 2'b01) begin errors++;
         $display("FAIL fast_done: got %b, required 01", fdone); end
   endtask

`ifdef AFE_SPI_BROADCAST_EN
   task automatic test_broadcast();
      int ch, diff;
      rec_t r;
      @(negedge clk);
      req_data = {DW'($urandom), 24'h000001};
      req_bcast = 1'b1;
      req_valid = 2'b01;
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++;
         $display("FAIL bcast_ready: got %b, required 01", req_ready); end
      wait_accept(ch);
      req_valid = 2'b00;
      req_bcast = 1'b0;
      last_m = 0;
      diff = 0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         #1;
         if (sck[0] !== sck[1] || sdi[0] !== sdi[1] || le[0] !== le[1]) diff++;
         if (done !== 2'b00) break;
      end
      checks++; if (diff != 0) begin errors++;
         $display("FAIL bcast_identical: %0d differing cycles, required 0", diff); end
      wait_done(r);
      checks++; if (r.dn !== 2'b11 || r.word0 !== 24'h000001 || r.word1 !== 24'h000001 ||
                    r.le0 != 5 || r.le1 != 5) begin errors++;
         $display("FAIL bcast_txn: done=%b w0=%h w1=%h le=%0d/%0d, required 11 000001 000001 5/5",
                  r.dn, r.word0, r.word1, r.le0, r.le1); end
   endtask
`endif

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      req_valid = 2'b00;
      req_data = '0;
      f_valid = 2'b00;
      f_data = '0;
`ifdef AFE_SPI_BROADCAST_EN
      req_bcast = 1'b0;
      f_bcast = 1'b0;
`endif
      test_reset();
      test_single();
      test_tie();
      test_held();
      test_random();
      test_reset_mid();
      test_param_corner();
`ifdef AFE_SPI_BROADCAST_EN
      test_broadcast();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
